// File: rtl/ula_seq.sv
// Registered WIDTH-bit ALU with start/done handshake; MUL is an unsigned shift-add
// multiplier that produces a 2*WIDTH-bit product over WIDTH iterations.
module ula_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  // state  | meaning
  // S_IDLE | ready=1, waiting for start; operands captured on accept
  // S_EXEC | result/flags registered (MUL arrives here after its last iteration)
  // S_MUL  | one shift-add iteration per cycle, cnt WIDTH-1 downto 0
  // S_FIN  | done=1 for this one cycle, then back to idle

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, acc_hi, acc_lo;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;

  logic             is_sub, c_msb, v_add, c_nxt, v_nxt;
  logic [WIDTH-1:0] b_eff, r_nxt, hi_nxt;
  logic [WIDTH:0]   sum, mul_sum;

  always_comb begin
    is_sub  = (op_q == OP_SUB) || (op_q == OP_SLT);
    b_eff   = is_sub ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    c_msb   = a_q[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    v_add   = c_msb ^ sum[WIDTH];
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    r_nxt   = '0;
    hi_nxt  = '0;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
    case (op_q)
      OP_AND: r_nxt = a_q & b_q;
      OP_OR:  r_nxt = a_q | b_q;
      OP_NOR: r_nxt = ~(a_q | b_q);
      OP_ADD, OP_SUB: begin
        r_nxt = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
        v_nxt = v_add;
      end
      OP_SLT: begin
        r_nxt = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v_add};
        c_nxt = sum[WIDTH];
        v_nxt = v_add;
      end
      OP_MUL: begin
        if (MUL_EN) begin
          r_nxt  = acc_lo;
          hi_nxt = acc_hi;
          v_nxt  = |acc_hi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= operation;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= CW'(WIDTH-1);
            ready  <= 1'b0;
            state  <= (operation == OP_MUL && MUL_EN) ? S_MUL : S_EXEC;
          end
        end
        S_MUL: begin
          // {carry,hi,lo} shifted right one place after the conditional add
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          if (cnt == '0) state <= S_EXEC;
          else           cnt   <= cnt - 1'b1;
        end
        S_EXEC: begin
          result    <= r_nxt;
          result_hi <= hi_nxt;
          cout      <= c_nxt;
          overflow  <= v_nxt;
          zero      <= (r_nxt == '0) && (hi_nxt == '0);
          done      <= 1'b1;
          state     <= S_FIN;
        end
        S_FIN: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
